// File: rtl/xor4_stim_toggle_gen.sv
// Four-channel square-wave stimulus source for the XOR4 stage.
// A start/stop FSM bounds the run window and pulses done when it closes.

module xor4_stim_chan #(
  parameter int CNT_W = 8,
  parameter int HALF  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic out_o
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (load_i) begin
      cnt_d = RELOAD;
      out_d = 1'b0;
    end else if (run_i) begin
      if (cnt_q == '0) begin
        cnt_d = RELOAD;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;
endmodule

module xor4_stim_toggle_gen #(
  parameter int CNT_W  = 8,
  parameter int HALF_A = 10,
  parameter int HALF_B = 7,
  parameter int HALF_C = 5,
  parameter int HALF_D = 1,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [LEN_W-1:0] run_len_i,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int NUM_CH = 4;
  localparam int HALF_TBL [NUM_CH] = '{HALF_A, HALF_B, HALF_C, HALF_D};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] elapsed_q, elapsed_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             load, run;
  logic [NUM_CH-1:0] ch_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      len_q     <= len_d;
    end
  end

  // stop wins over the length test; a zero length never terminates by itself
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN:  if (stop_i || (len_q != '0 && elapsed_q == len_q - LEN_W'(1))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load      = (state_q == IDLE) && start_i;
    run       = (state_q == RUN);
    elapsed_d = elapsed_q;
    len_d     = len_q;
    if (load) begin
      elapsed_d = '0;
      len_d     = run_len_i;
    end else if (run) begin
      elapsed_d = elapsed_q + LEN_W'(1);
    end
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (HALF_TBL[i] < 1 || HALF_TBL[i] > 2**CNT_W) begin : g_bad_half
      $error("half-period of channel %0d out of range 1..2**CNT_W", i);
    end
    xor4_stim_chan #(.CNT_W(CNT_W), .HALF(HALF_TBL[i])) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .run_i  (run),
      .out_o  (ch_out[i])
    );
  end

  assign a_o = ch_out[0];
  assign b_o = ch_out[1];
  assign c_o = ch_out[2];
  assign d_o = ch_out[3];
endmodule

// File: tb/tb_xor4_stim_toggle_gen.sv
// Directed bench for xor4_stim_toggle_gen with default parameters.
module tb_xor4_stim_toggle_gen;
  localparam int HA = 10, HB = 7, HC = 5, HD = 1;

  logic        clk, rst_n, start, stop;
  logic [15:0] run_len;
  logic        a, b, c, d, busy, done;
  int          n_vec = 0, n_bad = 0;

  xor4_stim_toggle_gen dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .run_len_i(run_len),
    .a_o(a), .b_o(b), .c_o(c), .d_o(d), .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // expected {a,b,c,d} after k RUN edges: channel parity of floor(k/HALF)
  function automatic logic [3:0] pat(input int k);
    return {1'((k/HA) & 1), 1'((k/HB) & 1), 1'((k/HC) & 1), 1'((k/HD) & 1)};
  endfunction

  function automatic logic [3:0] outs();
    return {a, b, c, d};
  endfunction

  // starts a run of length len; leaves the bench just after E0
  task automatic kick(input logic [15:0] len, input logic hold);
    run_len = len;
    start   = 1'b1;
    step();
    if (!hold) start = 1'b0;
    chk("e0_outs", 32'(outs()), 32'h0);
    chk("e0_busy", 32'(busy), 32'h1);
  endtask

  task automatic run15(input string tag);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk({tag, "_outs"}, 32'(outs()), 32'(pat(k)));
      chk({tag, "_busy"}, 32'(busy), 32'(k < 15));
      chk({tag, "_done"}, 32'(done), 32'(k == 15));
    end
    chk({tag, "_end"}, 32'(outs()), 32'hB);
    step();
    chk({tag, "_done_clr"}, 32'(done), 32'h0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
    chk({tag, "_hold"}, 32'(outs()), 32'hB);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; run_len = '0;
    // 1: reset
    repeat (3) step();
    chk("rst_outs", 32'(outs()), 32'h0);
    chk("rst_flags", 32'({busy, done}), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_quiet", 32'({outs(), busy, done}), 32'h0);
    end

    // 2: bounded run of 15 cycles
    kick(16'd15, 1'b0);
    run15("len15");
    step();
    chk("len15_hold2", 32'({outs(), busy, done}), 32'h2C);

    // 4: restart with start held through RUN and DONE
    kick(16'd15, 1'b1);
    run15("rehold");
    start = 1'b0;
    step();
    chk("rehold_idle", 32'({busy, done}), 32'h0);

    // 3: free-run, stop at the 101st RUN edge
    kick(16'd0, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      step();
      chk("free_outs", 32'(outs()), 32'(pat(k)));
      chk("free_busy", 32'(busy), 32'h1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_outs", 32'(outs()), 32'(pat(101)));
    chk("stop_flags", 32'({busy, done}), 32'h1);
    step();
    chk("stop_idle", 32'({busy, done}), 32'h0);
    chk("stop_hold", 32'(outs()), 32'(pat(101)));

    // 5: start and stop together in IDLE
    stop = 1'b1;
    kick(16'd0, 1'b0);
    step();
    stop = 1'b0;
    chk("ss_outs", 32'(outs()), 32'h1);
    chk("ss_flags", 32'({busy, done}), 32'h1);
    step();
    chk("ss_idle", 32'({busy, done}), 32'h0);

    // 6: async reset mid-run
    kick(16'd20, 1'b0);
    for (int k = 1; k <= 8; k++) step();
    chk("mid_outs", 32'(outs()), 32'h6);
    #1 rst_n = 1'b0;
    #1 chk("arst_all", 32'({outs(), busy, done}), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_hold", 32'({outs(), busy, done}), 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst", 32'({outs(), busy, done}), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
